// File: rtl/axi_pkg.sv
// Shared AXI4-Lite definitions used by the master, the slave model and benches.
//   resp_t  : BRESP/RRESP encodings
//   state_t : master FSM states
//   AXI_PROT_DEFAULT / AXI_STRB_BIT : fixed sideband values (unprivileged,
//             secure, data access; every byte lane written)
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;
  localparam logic       AXI_STRB_BIT     = 1'b1;

endpackage

// File: rtl/axi_intf.sv
// AXI4-Lite channel bundle (AW, W, B, AR, R).
//   MASTER : drives aw*/w*/ar* payload and valids, bready, rready
//   SLAVE  : drives awready, wready, bvalid/bresp, arready, rvalid/rdata/rresp
// Handshake: a transfer happens on a rising edge where valid && ready.
// A source holds valid and its payload stable until that edge; ready may
// change freely and never waits on anything but valid.
interface axi_intf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport MASTER (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport SLAVE (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_wdog_cnt.sv
// Saturating watchdog counter.
//   aclk, areset_n : clock, async active-low reset
//   clear          : treat the count as zero in this cycle (first cycle of a phase)
//   enable         : count this cycle
//   expired        : count has reached LIMIT-1 while enabled
// Because clear zeroes the count combinationally, the first cycle of a phase
// is count 0 and expiry lands exactly LIMIT-1 cycles after phase entry.
module axi_wdog_cnt #(
  parameter int LIMIT = 256
) (
  input  logic aclk,
  input  logic areset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;
  logic [W-1:0] cur;

  assign cur     = clear ? '0 : cnt;
  assign expired = enable && (cur == LAST);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      cnt <= '0;
    end else if (enable && (cur != LAST)) begin
      cnt <= cur + W'(1);
    end else begin
      cnt <= cur;
    end
  end
endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction
// out, one response back. A watchdog forces an SLVERR response if the slave
// stalls any phase for TIMEOUT_CYCLES.
//   aclk, areset_n          : clock, async active-low reset
//   cmd_valid/cmd_ready     : command handshake (cmd_ready = FSM idle)
//   cmd_write/addr/wdata    : command payload
//   rsp_valid/rsp_ready     : response handshake
//   rsp_write/rdata/resp    : response payload (rdata 0 for writes)
//   rsp_timeout             : response produced by the watchdog
//   fsm_state               : current FSM state for observation
//   axi                     : AXI4-Lite master channels
module axi_lite_master
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output state_t                fsm_state,
  axi_intf.MASTER               axi
);
  state_t state;
  logic   wdog_clr;
  logic   wdog_en;
  logic   wdog_exp;
  logic   phase_done;

  assign fsm_state = state;
  assign cmd_ready = (state == IDLE);
  assign wdog_en   = (state == WR_REQ) || (state == WR_RESP) ||
                     (state == RD_REQ) || (state == RD_DATA);

  assign axi.awprot = AXI_PROT_DEFAULT;
  assign axi.arprot = AXI_PROT_DEFAULT;
  assign axi.wstrb  = {(DATA_WIDTH/8){AXI_STRB_BIT}};

  // The current wait phase finishes at this edge. In WR_REQ a channel that
  // already handshook (valid low) counts as done.
  always_comb begin
    phase_done = 1'b0;
    case (state)
      WR_REQ:  phase_done = (!axi.awvalid || axi.awready) &&
                            (!axi.wvalid  || axi.wready);
      WR_RESP: phase_done = axi.bvalid;
      RD_REQ:  phase_done = axi.arready;
      RD_DATA: phase_done = axi.rvalid;
      default: phase_done = 1'b0;
    endcase
  end

  axi_wdog_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .aclk     (aclk),
    .areset_n (areset_n),
    .clear    (wdog_clr),
    .enable   (wdog_en),
    .expired  (wdog_exp)
  );

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state       <= IDLE;
      wdog_clr    <= 1'b0;
      axi.awvalid <= 1'b0;
      axi.awaddr  <= '0;
      axi.wvalid  <= 1'b0;
      axi.wdata   <= '0;
      axi.bready  <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.araddr  <= '0;
      axi.rready  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
      rsp_timeout <= 1'b0;
    end else begin
      // Pulses high for the first cycle of every new state.
      wdog_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            rsp_write <= cmd_write;
            wdog_clr  <= 1'b1;
            if (cmd_write) begin
              axi.awaddr  <= cmd_addr;
              axi.wdata   <= cmd_wdata;
              axi.awvalid <= 1'b1;
              axi.wvalid  <= 1'b1;
              state       <= WR_REQ;
            end else begin
              axi.araddr  <= cmd_addr;
              axi.arvalid <= 1'b1;
              state       <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (axi.awvalid && axi.awready) axi.awvalid <= 1'b0;
          if (axi.wvalid && axi.wready)   axi.wvalid  <= 1'b0;
          if (phase_done) begin
            axi.bready <= 1'b1;
            wdog_clr   <= 1'b1;
            state      <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (phase_done) begin
            axi.bready  <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_resp    <= axi.bresp;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            wdog_clr    <= 1'b1;
            state       <= RESP;
          end
        end
        RD_REQ: begin
          if (phase_done) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            wdog_clr    <= 1'b1;
            state       <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (phase_done) begin
            axi.rready  <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= axi.rdata;
            rsp_resp    <= axi.rresp;
            rsp_timeout <= 1'b0;
            wdog_clr    <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Watchdog override: a phase that completes on the expiry edge keeps
      // its real result; otherwise every AXI request is withdrawn.
      if (wdog_exp && !phase_done) begin
        axi.awvalid <= 1'b0;
        axi.wvalid  <= 1'b0;
        axi.arvalid <= 1'b0;
        axi.bready  <= 1'b0;
        axi.rready  <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_resp    <= SLVERR;
        rsp_rdata   <= '0;
        rsp_timeout <= 1'b1;
        wdog_clr    <= 1'b1;
        state       <= RESP;
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: behavioural AXI4-Lite slave with optional AW
// stall and RVALID suppression, table of single transactions, plus directed
// sequences for AW stall, response back-pressure, watchdog and mid-reset.
module tb_axi_lite_master;
  import axi_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          aclk = 1'b0;
  logic          areset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;
  state_t        fsm_state;

  axi_intf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .aclk        (aclk),
    .areset_n    (areset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_write   (rsp_write),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .rsp_timeout (rsp_timeout),
    .fsm_state   (fsm_state),
    .axi         (axi)
  );

  // ---------------- clock ----------------
  always #5 aclk = ~aclk;

  // ---------------- slave model ----------------
  int          aw_stall_cfg = 0;   // cycles AWREADY stays low per AW request
  logic        no_rvalid    = 1'b0; // slave never answers reads when set
  int          aw_wait;
  logic        aw_have, w_have;
  logic [31:0] aw_a, w_d;
  logic [31:0] mem [0:15];
  logic        aw_ok, w_ok;
  logic [31:0] wa, wd;
  int          b_cnt = 0;

  assign axi.awready = (aw_wait >= aw_stall_cfg);
  assign axi.wready  = 1'b1;
  assign axi.arready = 1'b1;

  always_comb begin
    aw_ok = aw_have || (axi.awvalid && axi.awready);
    w_ok  = w_have  || (axi.wvalid  && axi.wready);
    wa    = aw_have ? aw_a : axi.awaddr;
    wd    = w_have  ? w_d  : axi.wdata;
  end

  always @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      aw_wait    <= 0;
      aw_have    <= 1'b0;
      w_have     <= 1'b0;
      aw_a       <= '0;
      w_d        <= '0;
      axi.bvalid <= 1'b0;
      axi.bresp  <= 2'b00;
      axi.rvalid <= 1'b0;
      axi.rdata  <= '0;
      axi.rresp  <= 2'b00;
      mem[2]     <= 32'h1234_5678;
    end else begin
      if (axi.awvalid && axi.awready) begin
        aw_have <= 1'b1;
        aw_a    <= axi.awaddr;
        aw_wait <= 0;
      end else if (axi.awvalid) begin
        aw_wait <= aw_wait + 1;
      end else begin
        aw_wait <= 0;
      end
      if (axi.wvalid && axi.wready) begin
        w_have <= 1'b1;
        w_d    <= axi.wdata;
      end
      if (aw_ok && w_ok && !axi.bvalid) begin
        axi.bvalid <= 1'b1;
        aw_have    <= 1'b0;
        w_have     <= 1'b0;
        if (wa >= 32'h40) axi.bresp <= 2'b11;
        else begin
          axi.bresp      <= 2'b00;
          mem[wa[5:2]]   <= wd;
        end
      end
      if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
      if (axi.arvalid && axi.arready && !no_rvalid) begin
        axi.rvalid <= 1'b1;
        if (axi.araddr >= 32'h40) begin
          axi.rdata <= 32'hBAD0_BAD0;
          axi.rresp <= 2'b11;
        end else begin
          axi.rdata <= mem[axi.araddr[5:2]];
          axi.rresp <= 2'b00;
        end
      end
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
    end
  end

  always @(posedge aclk) begin
    if (areset_n && axi.bvalid && axi.bready) b_cnt <= b_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  int          exp_b  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic wait_accept(output logic ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!cmd_ready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (cmd_ready) begin
      @(posedge aclk);
      @(negedge aclk);
      cmd_valid = 1'b0;
      ok = 1'b1;
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  // lat = cycles after the accept cycle until rsp_valid is seen.
  task automatic wait_rsp(input int start, output int lat);
    lat = start;
    while (!rsp_valid && lat < 60) begin
      @(negedge aclk);
      lat++;
    end
    check("rsp_wait", rsp_valid, 1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    logic        ok;
    int          lat;
    logic [31:0] exp_d;
    exp_q.push_back(v.exp_rdata);
    drive_cmd(v.wr, v.addr, v.wdata);
    wait_accept(ok);
    check({tag, "_accept"}, ok, 1);
    wait_rsp(1, lat);
    check({tag, "_lat"}, lat, 3);
    exp_d = exp_q.pop_front();
    check({tag, "_rdata"}, rsp_rdata, exp_d);
    check({tag, "_resp"}, rsp_resp, v.exp_resp);
    check({tag, "_write"}, rsp_write, v.wr);
    check({tag, "_timeout"}, rsp_timeout, 0);
    if (v.wr) exp_b++;
    take_rsp();
    check({tag, "_cmd_ready_after"}, cmd_ready, 1);
  endtask

  vec_t vecs [9];

  initial begin
    logic ok;
    int   lat;

    vecs[0] = '{1'b1, 32'h04, 32'hDEAD_BEEF, 32'h0,         2'b00};
    vecs[1] = '{1'b0, 32'h04, 32'h0,         32'hDEAD_BEEF, 2'b00};
    vecs[2] = '{1'b1, 32'h10, 32'hA5A5_5A5A, 32'h0,         2'b00};
    vecs[3] = '{1'b0, 32'h10, 32'h0,         32'hA5A5_5A5A, 2'b00};
    vecs[4] = '{1'b0, 32'h08, 32'h0,         32'h1234_5678, 2'b00};
    vecs[5] = '{1'b1, 32'h44, 32'h0F0F_0F0F, 32'h0,         2'b11};
    vecs[6] = '{1'b0, 32'h44, 32'h0,         32'hBAD0_BAD0, 2'b11};
    vecs[7] = '{1'b1, 32'h04, 32'h0000_0001, 32'h0,         2'b00};
    vecs[8] = '{1'b0, 32'h04, 32'h0,         32'h0000_0001, 2'b00};

    // ---- reset ----
    areset_n  = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge aclk);
    check("reset_ctrl", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready,
                         axi.rready, rsp_valid, rsp_timeout}, 7'b0);
    check("reset_resp", rsp_resp, 2'b00);
    check("reset_rdata", rsp_rdata, 32'h0);
    areset_n = 1'b1;
    @(negedge aclk);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_state", fsm_state, IDLE);

    // ---- table of single transactions ----
    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // ---- AW stalled 3 cycles, W completes first ----
    aw_stall_cfg = 3;
    drive_cmd(1'b1, 32'h20, 32'hCAFE_F00D);
    wait_accept(ok);
    check("stall_accept", ok, 1);
    check("stall_c1_valids", {axi.awvalid, axi.wvalid}, 2'b11);
    @(negedge aclk);
    check("stall_c2_valids", {axi.awvalid, axi.wvalid}, 2'b10);
    check("stall_c2_awaddr", axi.awaddr, 32'h20);
    @(negedge aclk);
    check("stall_c3_valids", {axi.awvalid, axi.wvalid}, 2'b10);
    check("stall_c3_awaddr", axi.awaddr, 32'h20);
    @(negedge aclk);
    check("stall_c4_aw", {axi.awvalid, axi.awready}, 2'b11);
    check("stall_c4_awaddr", axi.awaddr, 32'h20);
    exp_b++;
    wait_rsp(4, lat);
    check("stall_lat", lat, 6);
    check("stall_resp", rsp_resp, 2'b00);
    take_rsp();
    aw_stall_cfg = 0;
    check("stall_b_count", b_cnt, exp_b);
    run_vec('{1'b0, 32'h20, 32'h0, 32'hCAFE_F00D, 2'b00}, "stall_rd");

    // ---- back-to-back, response held off 5 cycles ----
    drive_cmd(1'b1, 32'h24, 32'h1111_2222);
    wait_accept(ok);
    check("b2b_accept1", ok, 1);
    exp_b++;
    drive_cmd(1'b0, 32'h24, 32'h0);
    wait_rsp(1, lat);
    check("b2b_lat1", lat, 3);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("b2b_hold%0d", c),
            {rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_rdata, cmd_ready},
            {1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0});
      @(negedge aclk);
    end
    take_rsp();
    check("b2b_cmd_ready", cmd_ready, 1);
    wait_accept(ok);
    check("b2b_accept2", ok, 1);
    wait_rsp(1, lat);
    check("b2b_lat2", lat, 3);
    check("b2b_rdata", rsp_rdata, 32'h1111_2222);
    check("b2b_write", rsp_write, 0);
    take_rsp();

    // ---- read watchdog: slave never returns RVALID ----
    no_rvalid = 1'b1;
    drive_cmd(1'b0, 32'h28, 32'h0);
    wait_accept(ok);
    check("to_accept", ok, 1);
    @(negedge aclk);
    check("to_state_rd_data", fsm_state, RD_DATA);
    check("to_rready", axi.rready, 1);
    wait_rsp(2, lat);
    check("to_lat", lat, 2 + TO);
    check("to_resp", rsp_resp, 2'b10);
    check("to_timeout", rsp_timeout, 1);
    check("to_rdata", rsp_rdata, 32'h0);
    check("to_axi_quiet", {axi.rready, axi.arvalid}, 2'b00);
    take_rsp();
    no_rvalid = 1'b0;
    run_vec('{1'b0, 32'h04, 32'h0, 32'h0000_0001, 2'b00}, "post_to_rd");

    // ---- reset while in WR_REQ ----
    aw_stall_cfg = 10;
    drive_cmd(1'b1, 32'h30, 32'h5555_AAAA);
    wait_accept(ok);
    check("mrst_accept", ok, 1);
    check("mrst_valids_before", {axi.awvalid, axi.wvalid}, 2'b11);
    areset_n = 1'b0;
    #1;
    check("mrst_valids_now", {axi.awvalid, axi.wvalid}, 2'b00);
    check("mrst_rsp_now", rsp_valid, 0);
    repeat (2) @(negedge aclk);
    areset_n     = 1'b1;
    aw_stall_cfg = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      check($sformatf("mrst_quiet%0d", c), {rsp_valid, cmd_ready}, 2'b01);
    end
    run_vec('{1'b0, 32'h08, 32'h0, 32'h1234_5678, 2'b00}, "mrst_rd");
    check("final_b_count", b_cnt, exp_b);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
